hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Hazard stall unit: the counterpart to the EX/MEM forwarding path. It handles the hazards forwarding cannot resolve by holding or flushing pipeline registers.
- Detects load-use hazards between ID and EX, interlocks on multi-cycle MDU (mul/div) operations, and flushes IF/ID and ID/EX on a taken branch resolved in EX.
- Sits beside the ID stage. Drives the PC enable and the IF/ID and ID/EX register enable/clear controls.

Parameters:
- MDU_TIMEOUT, 64: max cycles in MDU_WAIT before mdu_err is raised.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- reg_src_1  input  5  rs1 of the instruction in ID.
- reg_src_2  input  5  rs2 of the instruction in ID.
- use_rs1  input  1  ID instruction reads rs1.
- use_rs2  input  1  ID instruction reads rs2.
- reg_dst_3stg  input  5  rd of the instruction in EX.
- mem_read_3stg  input  1  EX instruction is a load.
- mdu_start  input  1  EX instruction issues a multi-cycle MDU op this cycle.
- mdu_done  input  1  MDU result valid.
- branch_taken_3stg  input  1  taken branch or jump resolved in EX.
- stall_pc  output  1  hold the PC.
- stall_if_id  output  1  hold the IF/ID register.
- stall_id_ex  output  1  hold the ID/EX register.
- bubble_id_ex  output  1  load a NOP into ID/EX.
- flush_if_id  output  1  clear IF/ID.
- mdu_busy  output  1  state is MDU_WAIT.
- mdu_err  output  1  sticky timeout flag.
- stall_cycles  output  CNT_W  performance counter.
- flush_events  output  CNT_W  performance counter.

Behaviour:
- Reset (async, rst_n=0): state RUN, wait counter 0, mdu_err 0, both counters 0. All control outputs read 0 while in reset. Reset asserted mid-MDU_WAIT aborts the wait immediately.
- Control outputs are combinational from the inputs and the registered state, so they take effect in the same cycle.
- load_use condition: mem_read_3stg && reg_dst_3stg!=0 && ((use_rs1 && reg_dst_3stg==reg_src_1) || (use_rs2 && reg_dst_3stg==reg_src_2)).
- FSM states: RUN, MDU_WAIT.
- RUN, evaluated in priority order:
  1. branch_taken_3stg: flush_if_id=1 and bubble_id_ex=1; all stalls 0. A flush overrides a simultaneous load_use or mdu_start, and the state stays RUN.
  2. else mdu_start: go to MDU_WAIT next cycle, counter cleared to 0. No stall in the issue cycle.
  3. else load_use: stall_pc=1, stall_if_id=1, bubble_id_ex=1 for exactly one cycle. The next cycle the load is in MEM, forwarding covers it, and no repeat stall occurs.
- MDU_WAIT:
  - stall_pc, stall_if_id and stall_id_ex = 1; mdu_busy=1; branch_taken_3stg and load_use are ignored.
  - Counter increments each cycle.
  - mdu_done=1: stalls drop in the same cycle and the state returns to RUN next cycle.
  - Counter reaches MDU_TIMEOUT-1 without mdu_done: mdu_err set (sticky until reset) and the state is forced to RUN.
  - mdu_done together with mdu_start is legal: treated as done (no chained wait).
- Width rules: counter width is $clog2(MDU_TIMEOUT). Performance counters wrap modulo 2^CNT_W.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with stall_pc=1.
  - flush_events increments on every cycle with flush_if_id=1.
- Not defined: both ports remain present but are tied to 0 and no counter flops are built.

Decomposition:
- Package hazard_pkg:
  - State enum hz_state_t {RUN, MDU_WAIT}.
  - Constant REG_ZERO = 5'd0.
  - Shared localparam for the default MDU_TIMEOUT.
- One natural sub-module: hazard_perf_cnt, holding the two CNT_W counters. It is instantiated only under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use on rs1: mem_read_3stg=1, reg_dst_3stg=5, reg_src_1=5, use_rs1=1 -> stall_pc, stall_if_id and bubble_id_ex high for 1 cycle; 0 the next cycle once the EX inputs update.
- x0 and unused operand: reg_dst_3stg=0 with src=0, or a match only on rs2 with use_rs2=0 -> no stall.
- Branch beats load-use: branch_taken_3stg=1 together with a load_use match -> flush_if_id=1, bubble_id_ex=1, stall_pc=0.
- MDU wait: mdu_start pulse, mdu_done after 10 cycles -> stall_* and mdu_busy high 10 cycles, low in the done cycle, state RUN after; stall_cycles=10 with HAZARD_PERF_CNT_EN.
- Timeout: mdu_start, no mdu_done, MDU_TIMEOUT=8 -> mdu_err rises after 8 wait cycles, stays high; state RUN.
- Async reset mid-wait: rst_n low in cycle 3 of MDU_WAIT -> all outputs 0 immediately; RUN after release.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard stall unit.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0]  REG_ZERO        = 5'd0;
  localparam int unsigned MDU_TIMEOUT_DEF = 64;
  localparam int unsigned CNT_W_DEF       = 32;

  // True when a used source operand depends on a non-x0 destination.
  function automatic logic reg_dep(input logic [4:0] dst, input logic [4:0] src,
                                   input logic used);
    return used && (dst != REG_ZERO) && (dst == src);
  endfunction

endpackage

// File: rtl/hazard_stall_unit_perf_cnt.sv
// Performance counters for stall cycles and flush events; wrap modulo 2^CNT_W.
module hazard_perf_cnt #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_stall,
  input  logic             i_flush,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (i_stall) r_stall_cycles <= r_stall_cycles + 1'b1;
      if (i_flush) r_flush_events <= r_flush_events + 1'b1;
    end
  end

  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard stall unit: load-use interlock, MDU wait interlock, branch flush.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int unsigned MDU_TIMEOUT = MDU_TIMEOUT_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       reg_src_1,
  input  logic [4:0]       reg_src_2,
  input  logic             use_rs1,
  input  logic             use_rs2,
  input  logic [4:0]       reg_dst_3stg,
  input  logic             mem_read_3stg,
  input  logic             mdu_start,
  input  logic             mdu_done,
  input  logic             branch_taken_3stg,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             bubble_id_ex,
  output logic             flush_if_id,
  output logic             mdu_busy,
  output logic             mdu_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam int unsigned     WAIT_W    = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  hz_state_t         r_state;
  hz_state_t         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_mdu_err;
  logic              w_mdu_err_nxt;
  logic              w_load_use;
  logic              w_stall_pc;
  logic              w_stall_if_id;
  logic              w_stall_id_ex;
  logic              w_bubble_id_ex;
  logic              w_flush_if_id;
  logic              w_mdu_busy;

  assign w_load_use = mem_read_3stg &&
                      (reg_dep(reg_dst_3stg, reg_src_1, use_rs1) ||
                       reg_dep(reg_dst_3stg, reg_src_2, use_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= RUN;
      r_wait_cnt <= '0;
      r_mdu_err  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_mdu_err  <= w_mdu_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_mdu_err_nxt  = r_mdu_err;
    w_stall_pc     = 1'b0;
    w_stall_if_id  = 1'b0;
    w_stall_id_ex  = 1'b0;
    w_bubble_id_ex = 1'b0;
    w_flush_if_id  = 1'b0;
    w_mdu_busy     = 1'b0;
    case (r_state)
      RUN: begin
        if (branch_taken_3stg) begin
          w_flush_if_id  = 1'b1;
          w_bubble_id_ex = 1'b1;
        end else if (mdu_start) begin
          // A result already valid at issue needs no wait.
          if (!mdu_done) begin
            w_state_nxt    = MDU_WAIT;
            w_wait_cnt_nxt = '0;
          end
        end else if (w_load_use) begin
          w_stall_pc     = 1'b1;
          w_stall_if_id  = 1'b1;
          w_bubble_id_ex = 1'b1;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          w_state_nxt = RUN;
        end else begin
          w_stall_pc    = 1'b1;
          w_stall_if_id = 1'b1;
          w_stall_id_ex = 1'b1;
          w_mdu_busy    = 1'b1;
          if (r_wait_cnt == WAIT_LAST) begin
            w_mdu_err_nxt = 1'b1;
            w_state_nxt   = RUN;
          end else begin
            w_wait_cnt_nxt = r_wait_cnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  // Inputs feed the controls combinationally, so gate them while in reset.
  assign stall_pc     = rst_n & w_stall_pc;
  assign stall_if_id  = rst_n & w_stall_if_id;
  assign stall_id_ex  = rst_n & w_stall_id_ex;
  assign bubble_id_ex = rst_n & w_bubble_id_ex;
  assign flush_if_id  = rst_n & w_flush_if_id;
  assign mdu_busy     = rst_n & w_mdu_busy;
  assign mdu_err      = r_mdu_err;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(
    .CNT_W(CNT_W)
  ) u_perf_cnt (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_stall        (stall_pc),
    .i_flush        (flush_if_id),
    .o_stall_cycles (stall_cycles),
    .o_flush_events (flush_events)
  );
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: timeout-64 and timeout-8 instances checked against a model.
module tb_hazard_stall_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mr, st, dn, br;

  logic        s_pc  [2];
  logic        s_ifid[2];
  logic        s_idex[2];
  logic        s_bub [2];
  logic        s_fl  [2];
  logic        s_busy[2];
  logic        s_err [2];
  logic [31:0] s_stc [2];
  logic [31:0] s_flc [2];

  // model state per instance
  bit          m_wait  [2];
  int          m_waited[2];
  bit          m_err   [2];
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];

  int n_tests = 0;
  int n_fail  = 0;
  int pin     = 0;

  localparam int P_ZERO = 1, P_LU = 2, P_BR = 3, P_WAIT = 4, P_CNT10 = 5,
                 P_ERR8 = 6, P_ERR64 = 7, P_FLUSH3 = 8, P_RST = 9;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MDU_TIMEOUT(64), .CNT_W(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .reg_src_1(rs1), .reg_src_2(rs2), .use_rs1(u1), .use_rs2(u2),
    .reg_dst_3stg(rd), .mem_read_3stg(mr), .mdu_start(st), .mdu_done(dn), .branch_taken_3stg(br),
    .stall_pc(s_pc[0]), .stall_if_id(s_ifid[0]), .stall_id_ex(s_idex[0]), .bubble_id_ex(s_bub[0]),
    .flush_if_id(s_fl[0]), .mdu_busy(s_busy[0]), .mdu_err(s_err[0]),
    .stall_cycles(s_stc[0]), .flush_events(s_flc[0]));

  hazard_stall_unit #(.MDU_TIMEOUT(8), .CNT_W(32)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .reg_src_1(rs1), .reg_src_2(rs2), .use_rs1(u1), .use_rs2(u2),
    .reg_dst_3stg(rd), .mem_read_3stg(mr), .mdu_start(st), .mdu_done(dn), .branch_taken_3stg(br),
    .stall_pc(s_pc[1]), .stall_if_id(s_ifid[1]), .stall_id_ex(s_idex[1]), .bubble_id_ex(s_bub[1]),
    .flush_if_id(s_fl[1]), .mdu_busy(s_busy[1]), .mdu_err(s_err[1]),
    .stall_cycles(s_stc[1]), .flush_events(s_flc[1]));

  function automatic int tmo(input int k);
    return (k == 0) ? 64 : 8;
  endfunction

  // {stall_pc, stall_if_id, stall_id_ex, bubble_id_ex, flush_if_id, mdu_busy, mdu_err}
  function automatic logic [6:0] exp_vec(input bit waiting, input bit err, input logic rst,
                                         input logic [4:0] a1, input logic [4:0] a2,
                                         input logic e1, input logic e2, input logic [4:0] d,
                                         input logic ld, input logic start, input logic done,
                                         input logic brn);
    logic lu;
    lu = ld && d != 5'd0 && ((e1 && d == a1) || (e2 && d == a2));
    if (!rst)    return 7'b0;
    if (waiting) return done ? {6'b0, err} : {6'b111001, err};
    if (brn)     return {6'b000110, err};
    if (start)   return {6'b0, err};
    if (lu)      return {6'b110100, err};
    return {6'b0, err};
  endfunction

  function automatic logic [6:0] dut_vec(input int k);
    return {s_pc[k], s_ifid[k], s_idex[k], s_bub[k], s_fl[k], s_busy[k], s_err[k]};
  endfunction

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  // model advance
  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      for (int k = 0; k < 2; k++) begin
        if (!rst_n) begin
          m_wait[k] = 0; m_waited[k] = 0; m_err[k] = 0; m_stall[k] = '0; m_flush[k] = '0;
        end else begin
          logic [6:0] e;
          e = exp_vec(m_wait[k], m_err[k], rst_n, rs1, rs2, u1, u2, rd, mr, st, dn, br);
          if (e[6]) m_stall[k] = m_stall[k] + 1;
          if (e[2]) m_flush[k] = m_flush[k] + 1;
          if (m_wait[k]) begin
            if (dn) m_wait[k] = 0;
            else if (m_waited[k] == tmo(k) - 1) begin m_err[k] = 1; m_wait[k] = 0; end
            else m_waited[k]++;
          end else if (!br && st && !dn) begin
            m_wait[k] = 1; m_waited[k] = 0;
          end
        end
      end
    end
  end

  // compare process
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk("ctrl", k, 32'(dut_vec(k)),
            32'(exp_vec(m_wait[k], m_err[k], rst_n, rs1, rs2, u1, u2, rd, mr, st, dn, br)));
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles", k, s_stc[k], m_stall[k]);
        chk("flush_events", k, s_flc[k], m_flush[k]);
`else
        chk("stall_cycles", k, s_stc[k], 32'd0);
        chk("flush_events", k, s_flc[k], 32'd0);
`endif
      end
      case (pin)
        P_ZERO:  chk("pin_zero", 0, 32'(dut_vec(0) >> 1), 32'h00);
        P_LU:    chk("pin_loaduse", 0, 32'(dut_vec(0) >> 1), 32'h34);
        P_BR:    chk("pin_branch", 0, 32'(dut_vec(0) >> 1), 32'h06);
        P_WAIT:  chk("pin_mduwait", 0, 32'(dut_vec(0) >> 1), 32'h39);
`ifdef HAZARD_PERF_CNT_EN
        P_CNT10:  chk("pin_stall10", 0, s_stc[0], 32'd10);
        P_FLUSH3: chk("pin_flush3", 0, s_flc[0], 32'd3);
`else
        P_CNT10:  chk("pin_stall10", 0, s_stc[0], 32'd0);
        P_FLUSH3: chk("pin_flush3", 0, s_flc[0], 32'd0);
`endif
        P_ERR8:  chk("pin_err8", 1, 32'(dut_vec(1)), 32'h01);
        P_ERR64: chk("pin_err64", 0, 32'(dut_vec(0)), 32'h01);
        P_RST: begin
          chk("pin_rst", 0, 32'(dut_vec(0)), 32'h0);
          chk("pin_rst", 1, 32'(dut_vec(1)), 32'h0);
          chk("pin_rst_cnt", 0, s_stc[0] | s_flc[0], 32'h0);
        end
        default: ;
      endcase
    end
  end

  task automatic set_in(input logic [4:0] a1, input logic [4:0] a2, input logic e1,
                        input logic e2, input logic [4:0] d, input logic ld,
                        input logic start, input logic done, input logic brn);
    rs1 = a1; rs2 = a2; u1 = e1; u2 = e2; rd = d; mr = ld; st = start; dn = done; br = brn;
  endtask

  task automatic idle();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick(input int p);
    pin = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; idle(); tick(P_RST);
    rst_n = 1'b1; tick(P_ZERO);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // reset with live hazard inputs must still read all zero
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(P_RST);
    rst_n = 1'b1; idle(); tick(P_ZERO);

    // load-use on rs1, then EX moves on
    set_in(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick(P_LU);
    set_in(5'd5, 5'd9, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0); tick(P_ZERO);
    // x0 destination
    set_in(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0); tick(P_ZERO);
    // rs2 match but rs2 unused
    set_in(5'd3, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); tick(P_ZERO);
    // rs2 match and used
    set_in(5'd3, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0); tick(P_LU);
    // branch beats load-use and mdu_start
    set_in(5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1); tick(P_BR);
    idle(); tick(P_ZERO);

    // MDU wait of 10 cycles then done
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick(P_ZERO);
    idle();
    for (int i = 0; i < 10; i++) tick(P_WAIT);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); tick(P_ZERO);
    idle(); tick(P_CNT10);

    // timeout: 8-cycle instance first, then 64-cycle instance
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick(P_ZERO);
    idle();
    for (int i = 0; i < 8; i++) tick(P_WAIT);
    tick(P_ERR8);
    for (int i = 0; i < 55; i++) tick(P_WAIT);
    tick(P_ERR64);
    // load-use honoured again after timeout, err stays sticky
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick(P_LU);

    // start and done together: no wait
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0); tick(P_ZERO);
    idle(); tick(P_ZERO);

    // async reset in third wait cycle
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0); tick(P_ZERO);
    idle(); tick(P_WAIT); tick(P_WAIT);
    rst_n = 1'b0;
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1); tick(P_RST);
    rst_n = 1'b1; idle(); tick(P_ZERO);
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0); tick(P_LU);

    // three flushes
    do_reset();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) tick(P_BR);
    idle(); tick(P_FLUSH3);

    pin = 0;
    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
